// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data load/store
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic              i_kill_i,
   output logic              i_ack_o,
   output logic              i_rvalid_o,
   output logic [DATA_W-1:0] i_rdata_o,
   input  logic              d_req_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [3:0]        d_we_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state, state_nx;
   logic [SW-1:0] streak;
   logic          owner_d;   // 1: D port owns the transaction, 0: I port
   logic          kill_q;
   logic          grant_any;
   logic          grant_d;
   logic          kill_eff;

   // A kill arriving in the same cycle as the response still drops it
   assign kill_eff = kill_q | (i_kill_i & ~owner_d);

   // Next-state and arbitration decision
   always_comb begin
      state_nx  = state;
      grant_any = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (i_req_i || d_req_i) begin
               grant_any = 1'b1;
               grant_d   = d_req_i && !(i_req_i && (streak == STREAK_MAX));
               state_nx  = REQ;
            end
         end
         REQ:     if (mem_gnt_i)    state_nx = WAIT;
         WAIT:    if (mem_rvalid_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Latched transaction, streak, kill flag and registered response outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak      <= '0;
         owner_d     <= 1'b0;
         kill_q      <= 1'b0;
         i_ack_o     <= 1'b0;
         i_rvalid_o  <= 1'b0;
         i_rdata_o   <= '0;
         d_ack_o     <= 1'b0;
         d_rvalid_o  <= 1'b0;
         d_rdata_o   <= '0;
         mem_req_o   <= 1'b0;
         mem_addr_o  <= '0;
         mem_we_o    <= '0;
         mem_wdata_o <= '0;
      end else begin
         i_ack_o    <= 1'b0;
         d_ack_o    <= 1'b0;
         i_rvalid_o <= 1'b0;
         d_rvalid_o <= 1'b0;
         case (state)
            IDLE: begin
               kill_q <= 1'b0;
               if (grant_any) begin
                  owner_d     <= grant_d;
                  i_ack_o     <= ~grant_d;
                  d_ack_o     <= grant_d;
                  mem_req_o   <= 1'b1;
                  mem_addr_o  <= grant_d ? d_addr_i : i_addr_i;
                  mem_we_o    <= grant_d ? d_we_i : 4'b0000;
                  mem_wdata_o <= grant_d ? d_wdata_i : '0;
                  if (!grant_d)
                     streak <= '0;
                  else if (i_req_i && (streak != STREAK_MAX))
                     streak <= streak + SW'(1);
               end
            end
            REQ: begin
               if (!owner_d && i_kill_i) kill_q <= 1'b1;
               if (mem_gnt_i) mem_req_o <= 1'b0;
            end
            WAIT: begin
               if (!owner_d && i_kill_i) kill_q <= 1'b1;
               if (mem_rvalid_i) begin
                  kill_q <= 1'b0;
                  if (owner_d) begin
                     d_rvalid_o <= 1'b1;
                     if (mem_we_o == 4'b0000) d_rdata_o <= mem_rdata_i;
                  end else if (!kill_eff) begin
                     i_rvalid_o <= 1'b1;
                     i_rdata_o  <= mem_rdata_i;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int MAXS = 4;

   logic        clk, rst_n;
   logic        i_req_i, i_kill_i, i_ack_o, i_rvalid_o;
   logic [31:0] i_addr_i, i_rdata_o;
   logic        d_req_i, d_ack_o, d_rvalid_o;
   logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
   logic [3:0]  d_we_i, mem_we_o;
   logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_kill_i(i_kill_i),
      .i_ack_o(i_ack_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_wdata_i(d_wdata_i),
      .d_ack_o(d_ack_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_req_i = 0; i_addr_i = 0; i_kill_i = 0;
      d_req_i = 0; d_addr_i = 0; d_we_i = 0; d_wdata_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      step();
      step();
      rst_n = 1;
   endtask

   // One transaction with immediate grant and response; returns what was observed
   task automatic run_txn(input bit is_d, input logic [31:0] addr, input logic [3:0] we,
                          input logic [31:0] wd, input logic [31:0] rd_mem,
                          output bit ack_ok, output bit rv_ok, output logic [31:0] rd);
      if (is_d) begin d_req_i = 1; d_addr_i = addr; d_we_i = we; d_wdata_i = wd; end
      else begin i_req_i = 1; i_addr_i = addr; end
      step();
      ack_ok = (is_d ? (d_ack_o && !i_ack_o) : (i_ack_o && !d_ack_o)) && mem_req_o && (mem_addr_o == addr);
      if (is_d) d_req_i = 0; else i_req_i = 0;
      mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rd_mem;
      step();
      mem_rvalid_i = 0;
      rv_ok = is_d ? (d_rvalid_o && !i_rvalid_o) : (i_rvalid_o && !d_rvalid_o);
      rd = is_d ? d_rdata_o : i_rdata_o;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_inputs();
      i_req_i = 1; d_req_i = 1; mem_rvalid_i = 1; mem_gnt_i = 1;
      step();
      step();
      n_tests++;
      if ({i_ack_o, i_rvalid_o, i_rdata_o, d_ack_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ack=%b/%b rv=%b/%b req=%b addr=%h, required all 0",
                  i_ack_o, d_ack_o, i_rvalid_o, d_rvalid_o, mem_req_o, mem_addr_o);
      end
      rst_n = 1;
      clear_inputs();
   endtask

   task automatic test_single_load();
      bit silent = 1;
      do_reset();
      d_req_i = 1; d_addr_i = 32'h100; d_we_i = 0;
      step();
      n_tests++;
      if (d_ack_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 4'h0) begin
         n_fail++;
         $display("FAIL load_t1: ack=%b req=%b addr=%h we=%h, required 1 1 00000100 0", d_ack_o, mem_req_o, mem_addr_o, mem_we_o);
      end
      silent &= !i_ack_o && !i_rvalid_o;
      d_req_i = 0; mem_gnt_i = 1;
      step();
      n_tests++;
      if (mem_req_o !== 1'b0 || d_ack_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL load_t2: req=%b ack=%b rv=%b, required 0 0 0", mem_req_o, d_ack_o, d_rvalid_o);
      end
      silent &= !i_ack_o && !i_rvalid_o;
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
      step();
      mem_rvalid_i = 0;
      n_tests++;
      if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL load_t3: rv=%b rdata=%h, required 1 deadbeef", d_rvalid_o, d_rdata_o);
      end
      silent &= !i_ack_o && !i_rvalid_o && (i_rdata_o == 0);
      n_tests++;
      if (!silent) begin
         n_fail++;
         $display("FAIL load_i_silent: i port active (ack=%b rv=%b rdata=%h), required silent", i_ack_o, i_rvalid_o, i_rdata_o);
      end
      step();
      n_tests++;
      if (d_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL load_rv_pulse: rv=%b one cycle later, required 0", d_rvalid_o);
      end
   endtask

   task automatic test_store_stall();
      int acks = 0;
      bit stable = 1;
      do_reset();
      d_req_i = 1; d_addr_i = 32'h200; d_we_i = 4'b0011; d_wdata_i = 32'h12345678;
      step();
      for (int c = 0; c < 4; c++) begin
         stable &= (mem_req_o === 1'b1) && (mem_addr_o === 32'h200) &&
                   (mem_we_o === 4'b0011) && (mem_wdata_o === 32'h12345678);
         acks += int'(d_ack_o);
         d_req_i = 0;
         mem_gnt_i = (c == 3);
         step();
      end
      n_tests++;
      if (!stable) begin
         n_fail++;
         $display("FAIL store_stable: mem outputs changed during stall (now req=%b addr=%h we=%h wd=%h), required 1 200 3 12345678",
                  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o);
      end
      n_tests++;
      if (mem_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL store_wait_req: req=%b, required 0", mem_req_o);
      end
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFEF00D;
      step();
      mem_rvalid_i = 0;
      n_tests++;
      if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL store_resp: rv=%b rdata=%h, required 1 00000000", d_rvalid_o, d_rdata_o);
      end
      n_tests++;
      if (acks != 1) begin
         n_fail++;
         $display("FAIL store_ack_count: %0d acks, required 1", acks);
      end
      step();
      n_tests++;
      if (d_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL store_rv_once: rv=%b, required 0", d_rvalid_o);
      end
   endtask

   task automatic test_starvation();
      byte got[10];
      int ng = 0;
      int s = 0;
      bit wt = 0;
      bit both = 0;
      do_reset();
      i_req_i = 1; i_addr_i = 32'h1000; d_req_i = 1; d_addr_i = 32'h2000;
      for (int cyc = 0; cyc < 80 && ng < 10; cyc++) begin
         if (i_ack_o && d_ack_o) both = 1;
         if (d_ack_o) begin got[ng] = "D"; ng++; end
         else if (i_ack_o) begin got[ng] = "I"; ng++; end
         mem_gnt_i = 0; mem_rvalid_i = 0;
         if (wt) begin mem_rvalid_i = 1; mem_rdata_i = $urandom; wt = 0; end
         else if (mem_req_o) begin mem_gnt_i = 1; wt = 1; end
         step();
      end
      clear_inputs();
      n_tests++;
      if (ng != 10 || both) begin
         n_fail++;
         $display("FAIL starve_grants: %0d grants both_acked=%b, required 10 grants none shared", ng, both);
      end
      for (int k = 0; k < 10 && k < ng; k++) begin
         byte e;
         if (s == MAXS) begin e = "I"; s = 0; end
         else begin e = "D"; s++; end
         n_tests++;
         if (got[k] != e) begin
            n_fail++;
            $display("FAIL starve_order[%0d]: got %c, required %c", k, got[k], e);
         end
      end
   endtask

   task automatic test_kill();
      bit ack_ok, rv_ok;
      logic [31:0] rd;
      do_reset();
      run_txn(0, 32'h3C, 0, 0, 32'hAAAA5555, ack_ok, rv_ok, rd);
      n_tests++;
      if (!ack_ok || !rv_ok || rd !== 32'hAAAA5555) begin
         n_fail++;
         $display("FAIL kill_setup: ack_ok=%b rv_ok=%b rdata=%h, required 1 1 aaaa5555", ack_ok, rv_ok, rd);
      end
      i_req_i = 1; i_addr_i = 32'h40;
      step();
      n_tests++;
      if (i_ack_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_we_o !== 4'h0 || mem_wdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL kill_req: ack=%b addr=%h we=%h wd=%h, required 1 40 0 0", i_ack_o, mem_addr_o, mem_we_o, mem_wdata_o);
      end
      i_req_i = 0; mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; i_kill_i = 1;
      step();
      i_kill_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00000013;
      step();
      mem_rvalid_i = 0;
      n_tests++;
      if (i_rvalid_o !== 1'b0 || i_rdata_o !== 32'hAAAA5555) begin
         n_fail++;
         $display("FAIL kill_suppress: rv=%b rdata=%h, required 0 aaaa5555", i_rvalid_o, i_rdata_o);
      end
      step();
      n_tests++;
      if (i_rvalid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL kill_late_rv: rv=%b, required 0", i_rvalid_o);
      end
      run_txn(0, 32'h44, 0, 0, 32'h11223344, ack_ok, rv_ok, rd);
      n_tests++;
      if (!ack_ok || !rv_ok || rd !== 32'h11223344) begin
         n_fail++;
         $display("FAIL kill_next_fetch: ack_ok=%b rv_ok=%b rdata=%h, required 1 1 11223344", ack_ok, rv_ok, rd);
      end
   endtask

   task automatic test_reset_midop();
      bit ack_ok, rv_ok, all_ok = 1;
      logic [31:0] rd;
      do_reset();
      i_req_i = 1; i_addr_i = 32'h80;
      for (int k = 0; k < MAXS; k++) begin
         run_txn(1, 32'h400 + 32'(k * 4), 0, 0, 32'h100 + 32'(k), ack_ok, rv_ok, rd);
         all_ok &= ack_ok && rv_ok;
      end
      i_req_i = 0;
      n_tests++;
      if (!all_ok) begin
         n_fail++;
         $display("FAIL midop_prefill: D transactions ok=%b, required 1", all_ok);
      end
      d_req_i = 1; d_addr_i = 32'h500; d_we_i = 0;
      step();
      d_req_i = 0; mem_gnt_i = 1;
      step();
      mem_gnt_i = 0; rst_n = 0;
      step();
      rst_n = 1;
      n_tests++;
      if ({i_ack_o, i_rvalid_o, i_rdata_o, d_ack_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o} !== '0) begin
         n_fail++;
         $display("FAIL midop_outputs: req=%b addr=%h d_rdata=%h rv=%b/%b, required all 0",
                  mem_req_o, mem_addr_o, d_rdata_o, i_rvalid_o, d_rvalid_o);
      end
      mem_rvalid_i = 1; mem_rdata_i = 32'h5A5A5A5A;
      step();
      mem_rvalid_i = 0;
      n_tests++;
      if (i_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL midop_stray: rv=%b/%b d_rdata=%h, required 0 0 00000000", i_rvalid_o, d_rvalid_o, d_rdata_o);
      end
      i_req_i = 1;
      run_txn(1, 32'h300, 0, 0, 32'h00000077, ack_ok, rv_ok, rd);
      i_req_i = 0;
      n_tests++;
      if (!ack_ok || !rv_ok || rd !== 32'h77) begin
         n_fail++;
         $display("FAIL midop_after: ack_ok=%b rv_ok=%b rdata=%h, required 1 1 00000077 (D first, streak cleared)", ack_ok, rv_ok, rd);
      end
   endtask

   task automatic test_random();
      bit          m_busy = 0, m_req = 0, m_owner_d = 0, m_kill = 0, pick_d;
      bit          e_ack_i = 0, e_ack_d = 0, e_rv_i = 0, e_rv_d = 0;
      int          m_streak = 0;
      logic [31:0] m_addr = 0, m_wd = 0, m_rd_i = 0, m_rd_d = 0;
      logic [3:0]  m_we = 0;
      bit          r_wait = 0;
      int          r_gcnt = -1, r_rcnt = 0;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         n_tests++;
         if (i_ack_o !== e_ack_i || d_ack_o !== e_ack_d || i_rvalid_o !== e_rv_i || d_rvalid_o !== e_rv_d) begin
            n_fail++;
            $display("FAIL rand_pulses@%0d: ack=%b%b rv=%b%b, required ack=%b%b rv=%b%b",
                     cyc, i_ack_o, d_ack_o, i_rvalid_o, d_rvalid_o, e_ack_i, e_ack_d, e_rv_i, e_rv_d);
         end
         n_tests++;
         if (i_rdata_o !== m_rd_i || d_rdata_o !== m_rd_d) begin
            n_fail++;
            $display("FAIL rand_rdata@%0d: i=%h d=%h, required i=%h d=%h", cyc, i_rdata_o, d_rdata_o, m_rd_i, m_rd_d);
         end
         n_tests++;
         if (mem_req_o !== m_req || (m_req && (mem_addr_o !== m_addr || mem_we_o !== m_we || mem_wdata_o !== m_wd))) begin
            n_fail++;
            $display("FAIL rand_mem@%0d: req=%b addr=%h we=%h wd=%h, required req=%b addr=%h we=%h wd=%h",
                     cyc, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, m_req, m_addr, m_we, m_wd);
         end
         // requesters
         if (i_req_i) begin
            if (i_ack_o) begin i_req_i = 1'($urandom_range(0, 1)); i_addr_i = $urandom; end
         end else if ($urandom_range(0, 2) == 0) begin
            i_req_i = 1; i_addr_i = $urandom;
         end
         if (d_req_i) begin
            if (d_ack_o) begin
               d_req_i = 1'($urandom_range(0, 1)); d_addr_i = $urandom;
               d_we_i = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0; d_wdata_i = $urandom;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            d_req_i = 1; d_addr_i = $urandom;
            d_we_i = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0; d_wdata_i = $urandom;
         end
         i_kill_i = ($urandom_range(0, 7) == 0);
         // memory
         mem_gnt_i = 0; mem_rvalid_i = 0;
         if (r_wait) begin
            if (r_rcnt == 0) begin mem_rvalid_i = 1; mem_rdata_i = $urandom; r_wait = 0; end
            else r_rcnt--;
         end else if (mem_req_o) begin
            if (r_gcnt < 0) r_gcnt = $urandom_range(0, 3);
            if (r_gcnt == 0) begin
               mem_gnt_i = 1; r_wait = 1; r_rcnt = $urandom_range(0, 3); r_gcnt = -1;
            end else begin
               r_gcnt--;
               if ($urandom_range(0, 9) == 0) begin mem_rvalid_i = 1; mem_rdata_i = $urandom; end
            end
         end else if ($urandom_range(0, 9) == 0) begin
            mem_rvalid_i = 1; mem_rdata_i = $urandom;
         end
         // reference model: one transaction at a time, decided from the arbitration rules
         e_ack_i = 0; e_ack_d = 0; e_rv_i = 0; e_rv_d = 0;
         if (!m_busy) begin
            if (i_req_i || d_req_i) begin
               pick_d = d_req_i && !(i_req_i && m_streak == MAXS);
               m_busy = 1; m_req = 1; m_owner_d = pick_d; m_kill = 0;
               if (pick_d) begin
                  e_ack_d = 1; m_addr = d_addr_i; m_we = d_we_i; m_wd = d_wdata_i;
                  if (i_req_i && m_streak < MAXS) m_streak++;
               end else begin
                  e_ack_i = 1; m_addr = i_addr_i; m_we = 0; m_wd = 0; m_streak = 0;
               end
            end
         end else begin
            if (!m_owner_d && i_kill_i) m_kill = 1;
            if (m_req) begin
               if (mem_gnt_i) m_req = 0;
            end else if (mem_rvalid_i) begin
               m_busy = 0;
               if (m_owner_d) begin
                  e_rv_d = 1;
                  if (m_we == 0) m_rd_d = mem_rdata_i;
               end else if (!m_kill) begin
                  e_rv_i = 1; m_rd_i = mem_rdata_i;
               end
            end
         end
         step();
      end
      clear_inputs();
   endtask

   initial begin
      rst_n = 0;
      clear_inputs();
      test_reset();
      test_single_load();
      test_store_stall();
      test_starvation();
      test_kill();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
